// File: rtl/and_gate.sv
// and_gate: bitwise two-operand AND with 0..2 output register stages,
// a valid qualifier travelling alongside the data, and reduction flags
// (all_ones / any_zero) derived from the visible result.
//
// Optional feature, macro AND_GATE_STATS_EN: adds a 16-bit saturating
// counter (ones_count) of cycles where y_valid=1 and all_ones=1.

// ---------------------------------------------------------------------------
// Single-bit lane: AND plus its own copy of the output pipeline.
// ---------------------------------------------------------------------------
module and_gate_lane #(
   parameter int STAGES = 0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic a,
   input  logic b,
   output logic y
);

   if (STAGES == 0) begin : g_comb
      // Combinational lane still honours reset so y reads 0 while rst_n=0.
      logic clk_unused;
      assign clk_unused = clk;
      assign y = rst_n & a & b;
   end else begin : g_pipe
      logic [STAGES:1] d_pipe;

      // Data shifts every cycle regardless of valid; reset clears all stages.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            d_pipe <= '0;
         end else begin
            d_pipe[1] <= a & b;
            for (int s = 2; s <= STAGES; s++) d_pipe[s] <= d_pipe[s-1];
         end
      end

      assign y = d_pipe[STAGES];
   end

endmodule

// ---------------------------------------------------------------------------
// Top
// ---------------------------------------------------------------------------
module and_gate #(
   parameter int WIDTH       = 1,
   parameter int PIPE_STAGES = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic [WIDTH-1:0] y,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             in_valid,
   output logic             y_valid,
   output logic             all_ones,
   output logic             any_zero
`ifdef AND_GATE_STATS_EN
   ,
   output logic [15:0]      ones_count
`endif
);

   // Parameter legality, caught at elaboration.
   if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
      $error("and_gate: WIDTH must be in 1..64");
   end
   if (PIPE_STAGES < 0 || PIPE_STAGES > 2) begin : g_bad_stages
      $error("and_gate: PIPE_STAGES must be 0, 1 or 2");
   end

   // One lane per bit; bits never interact, so X stays in its own lane.
   and_gate_lane #(.STAGES(PIPE_STAGES)) u_lane [WIDTH-1:0] (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (a),
      .b     (b),
      .y     (y)
   );

   if (PIPE_STAGES == 0) begin : g_vld_comb
      assign y_valid = rst_n & in_valid;
   end else begin : g_vld_pipe
      logic [PIPE_STAGES:1] vld_pipe;

      // Valid bit follows the same stage count as the data.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld_pipe <= '0;
         end else begin
            vld_pipe[1] <= in_valid;
            for (int s = 2; s <= PIPE_STAGES; s++) vld_pipe[s] <= vld_pipe[s-1];
         end
      end

      assign y_valid = vld_pipe[PIPE_STAGES];
   end

   // Flags come from the visible y so they always agree with it
   // (y=0 during reset gives all_ones=0, any_zero=1).
   assign all_ones = &y;
   assign any_zero = ~&y;

`ifdef AND_GATE_STATS_EN
   // Saturating count of qualified all-ones results.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ones_count <= '0;
      end else if (y_valid && all_ones && ones_count != 16'hFFFF) begin
         ones_count <= ones_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_and_gate.sv
// Directed bench for and_gate: several parameterisations share one clock
// and reset; expected values are hand-computed constants.
`timescale 1ns/1ps
module tb_and_gate;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // WIDTH=1, PIPE_STAGES=0
   logic a1, b1, v1, y1, yv1, ao1, az1;
   and_gate #(.WIDTH(1), .PIPE_STAGES(0)) u_w1p0 (
      .clk(clk), .rst_n(rst_n), .y(y1), .a(a1), .b(b1), .in_valid(v1),
      .y_valid(yv1), .all_ones(ao1), .any_zero(az1));

   // WIDTH=8, PIPE_STAGES=0
   logic [7:0] a8, b8, y8;
   logic v8, yv8, ao8, az8;
   and_gate #(.WIDTH(8), .PIPE_STAGES(0)) u_w8p0 (
      .clk(clk), .rst_n(rst_n), .y(y8), .a(a8), .b(b8), .in_valid(v8),
      .y_valid(yv8), .all_ones(ao8), .any_zero(az8));

   // WIDTH=8, PIPE_STAGES=2
   logic [7:0] ap2, bp2, yp2;
   logic vp2, yvp2, aop2, azp2;
   and_gate #(.WIDTH(8), .PIPE_STAGES(2)) u_w8p2 (
      .clk(clk), .rst_n(rst_n), .y(yp2), .a(ap2), .b(bp2), .in_valid(vp2),
      .y_valid(yvp2), .all_ones(aop2), .any_zero(azp2));

   // WIDTH=8, PIPE_STAGES=1
   logic [7:0] ap1, bp1, yp1;
   logic vp1, yvp1, aop1, azp1;
   and_gate #(.WIDTH(8), .PIPE_STAGES(1)) u_w8p1 (
      .clk(clk), .rst_n(rst_n), .y(yp1), .a(ap1), .b(bp1), .in_valid(vp1),
      .y_valid(yvp1), .all_ones(aop1), .any_zero(azp1));

`ifdef AND_GATE_STATS_EN
   // WIDTH=1, PIPE_STAGES=1 with statistics counter
   logic as, bs, vs, ys, yvs, aos, azs;
   logic [15:0] cnt;
   and_gate #(.WIDTH(1), .PIPE_STAGES(1)) u_stats (
      .clk(clk), .rst_n(rst_n), .y(ys), .a(as), .b(bs), .in_valid(vs),
      .y_valid(yvs), .all_ones(aos), .any_zero(azs), .ones_count(cnt));
`endif

   logic [7:0] tt_a, tt_b, tt_y, tt_ao;

   initial begin
      // ---- reset state, with live inputs held high ----
      rst_n = 1'b0;
      a1 = 1'b1; b1 = 1'b1; v1 = 1'b1;
      a8 = 8'hFF; b8 = 8'hFF; v8 = 1'b1;
      ap2 = 8'hFF; bp2 = 8'hFF; vp2 = 1'b1;
      ap1 = 8'hFF; bp1 = 8'hFF; vp1 = 1'b1;
`ifdef AND_GATE_STATS_EN
      as = 1'b0; bs = 1'b0; vs = 1'b0;
`endif
      #2;
      chk("rst_w1p0_y",  64'(y1),  64'd0);
      chk("rst_w1p0_yv", 64'(yv1), 64'd0);
      chk("rst_w1p0_ao", 64'(ao1), 64'd0);
      chk("rst_w1p0_az", 64'(az1), 64'd1);
      chk("rst_w8p0_y",  64'(y8),  64'd0);
      chk("rst_w8p0_az", 64'(az8), 64'd1);
      tick; tick;
      chk("rst_p2_y",  64'(yp2),  64'd0);
      chk("rst_p2_yv", 64'(yvp2), 64'd0);
      chk("rst_p1_yv", 64'(yvp1), 64'd0);
      chk("rst_p1_ao", 64'(aop1), 64'd0);
      chk("rst_p1_az", 64'(azp1), 64'd1);
      vp2 = 1'b0; vp1 = 1'b0;
      rst_n = 1'b1;

      // ---- WIDTH=1 truth table ----
      tt_a = 8'b1010; tt_b = 8'b1100; tt_y = 8'b1000; tt_ao = 8'b1000;
      for (int i = 0; i < 4; i++) begin
         a1 = tt_a[i]; b1 = tt_b[i]; v1 = 1'b1;
         #5;
         chk($sformatf("tt%0d_y", i),  64'(y1),  64'(tt_y[i]));
         chk($sformatf("tt%0d_yv", i), 64'(yv1), 64'd1);
         chk($sformatf("tt%0d_ao", i), 64'(ao1), 64'(tt_ao[i]));
      end
      v1 = 1'b0;
      #1;
      chk("w1p0_yv_follow", 64'(yv1), 64'd0);

      // ---- WIDTH=8 combinational ----
      a8 = 8'hF0; b8 = 8'h3C; v8 = 1'b1;
      #1;
      chk("w8p0_y_f0_3c",  64'(y8),  64'h30);
      chk("w8p0_az_f0_3c", 64'(az8), 64'd1);
      chk("w8p0_ao_f0_3c", 64'(ao8), 64'd0);
      a8 = 8'hFF; b8 = 8'hFF;
      #1;
      chk("w8p0_y_ff",  64'(y8),  64'hFF);
      chk("w8p0_ao_ff", 64'(ao8), 64'd1);
      chk("w8p0_az_ff", 64'(az8), 64'd0);

      // ---- PIPE_STAGES=2 back-to-back ----
      tick;
      ap2 = 8'hAA; bp2 = 8'h0F; vp2 = 1'b1;
      tick;
      chk("p2_e1_yv", 64'(yvp2), 64'd0);
      ap2 = 8'h55; bp2 = 8'hFF; vp2 = 1'b1;
      tick;
      chk("p2_e2_y",  64'(yp2),  64'h0A);
      chk("p2_e2_yv", 64'(yvp2), 64'd1);
      vp2 = 1'b0;
      tick;
      chk("p2_e3_y",  64'(yp2),  64'h55);
      chk("p2_e3_yv", 64'(yvp2), 64'd1);
      tick;
      chk("p2_e4_yv", 64'(yvp2), 64'd0);

      // ---- PIPE_STAGES=1 valid toggle 1,0,1 ----
      ap1 = 8'hFF; bp1 = 8'hFF; vp1 = 1'b1;
      #1;
      chk("p1_tog_pre_yv", 64'(yvp1), 64'd0);
      tick;
      chk("p1_tog1_yv", 64'(yvp1), 64'd1);
      chk("p1_tog1_y",  64'(yp1),  64'hFF);
      chk("p1_tog1_ao", 64'(aop1), 64'd1);
      chk("p1_tog1_az", 64'(azp1), 64'd0);
      vp1 = 1'b0;
      tick;
      chk("p1_tog0_yv", 64'(yvp1), 64'd0);
      vp1 = 1'b1;
      tick;
      chk("p1_tog2_yv", 64'(yvp1), 64'd1);
      vp1 = 1'b0;
      tick;
      chk("p1_tog3_yv", 64'(yvp1), 64'd0);

      // ---- PIPE_STAGES=1 async reset mid-flight ----
      ap1 = 8'h3C; bp1 = 8'hFF; vp1 = 1'b1;
      tick;
      chk("p1_inflight_y",  64'(yp1),  64'h3C);
      chk("p1_inflight_yv", 64'(yvp1), 64'd1);
      vp1 = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("p1_arst_y",  64'(yp1),  64'd0);
      chk("p1_arst_yv", 64'(yvp1), 64'd0);
      chk("p1_arst_az", 64'(azp1), 64'd1);
      #1 rst_n = 1'b1;
      tick;
      chk("p1_post_rst_yv0", 64'(yvp1), 64'd0);
      tick;
      chk("p1_post_rst_yv1", 64'(yvp1), 64'd0);

`ifdef AND_GATE_STATS_EN
      // ---- statistics counter ----
      #1 rst_n = 1'b0;
      #1 rst_n = 1'b1;
      chk("st_rst", 64'(cnt), 64'd0);
      tick;
      // (1,1,v) (1,0,v) (1,1,v) (1,1,!v) (1,0,v) (1,1,v): three qualifying
      tt_a = 8'b111111; tt_b = 8'b101101; tt_y = 8'b110111;
      for (int i = 0; i < 6; i++) begin
         as = tt_a[i]; bs = tt_b[i]; vs = tt_y[i];
         tick;
      end
      vs = 1'b0;
      tick; tick;
      chk("st_count3", 64'(cnt), 64'd3);
      as = 1'b1; bs = 1'b1; vs = 1'b1;
      for (int i = 0; i < 65531; i++) tick;
      vs = 1'b0;
      tick; tick;
      chk("st_fffe", 64'(cnt), 64'hFFFE);
      vs = 1'b1;
      for (int i = 0; i < 3; i++) tick;
      vs = 1'b0;
      tick; tick;
      chk("st_sat", 64'(cnt), 64'hFFFF);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
